switch8_reader: RTL and testbench
=================================

Name: switch8_reader

Overview:
- Input-side counterpart of the 8-LED output path: reads 8 board switches/buttons.
- Synchronises each asynchronous pin into fpga_clk and debounces each bit independently.
- Emits per-bit rise/fall pulses and a valid/ready change-event record for the control logic.
- Sits between board pins and the system controller / LED counter logic.

Parameters:
- DEBOUNCE_CYCLES, 500000, consecutive fpga_clk cycles a new level must hold before acceptance (10 ms at 50 MHz); must be >= 2.
- CNT_W, 20, debounce counter width; must satisfy 2^CNT_W > DEBOUNCE_CYCLES.

Ports:
- fpga_clk  in  1  system clock; all logic on the rising edge.
- sys_init_ctrl_n  in  1  reset; one clock, reset is asynchronous and active-low.
- sw  in  8  raw asynchronous switch/button pins; 1 = pressed/on.
- sw_state  out  8  debounced level per bit.
- sw_rise  out  8  one-cycle pulse per bit on debounced 0->1.
- sw_fall  out  8  one-cycle pulse per bit on debounced 1->0.
- evt_valid  out  1  change event pending.
- evt_data  out  8  sw_state snapshot belonging to the pending event.
- evt_ready  in  1  consumer accepts the event when evt_valid && evt_ready.
- evt_overrun  out  1  sticky flag: an unaccepted event was overwritten.

Behaviour:
- Reset (sys_init_ctrl_n = 0, asynchronous): both sync stages, all debounce counters, sw_state, sw_rise, sw_fall, evt_valid, evt_data and evt_overrun are 0. Reset release is taken synchronously by the design; no event is generated by reset itself.
- Sync: 2-flop synchroniser per bit (sw -> s1 -> s2). No combinational path from sw to any output.
- Debounce, per bit i, every cycle:
  - If s2[i] == sw_state[i], cnt[i] <= 0.
  - Else if cnt[i] == DEBOUNCE_CYCLES-1, then sw_state[i] <= s2[i] and cnt[i] <= 0.
  - Else cnt[i] <= cnt[i] + 1.
  - Any return of s2[i] to sw_state[i] before the terminal count restarts the count from 0.
  - Net latency from the first clock edge sampling a stable new pin level to the sw_state change is 2 + DEBOUNCE_CYCLES edges.
- Pulses:
  - sw_rise[i] / sw_fall[i] are registered and high only in the first cycle sw_state[i] shows its new value.
  - Several bits may pulse in the same cycle.
- Event handshake (change = any sw_rise | sw_fall bit set):
  - Change, no event pending: evt_valid <= 1, evt_data <= new sw_state.
  - Change while evt_valid && evt_ready in the same cycle: new event replaces it; evt_valid stays 1; no overrun.
  - Change while evt_valid && !evt_ready: evt_data overwritten with newest sw_state; evt_overrun <= 1.
  - No change and evt_valid && evt_ready: evt_valid <= 0 and evt_overrun <= 0.
  - evt_data is stable while evt_valid && !evt_ready and no change occurs. evt_ready while !evt_valid is ignored.
- Arithmetic: counters are unsigned CNT_W bits and never exceed DEBOUNCE_CYCLES-1, so they cannot wrap.
- Mid-operation reset clears partial debounce counts. After release, a held pin needs the full 2 + DEBOUNCE_CYCLES again.

Test Plan:
- DEBOUNCE_CYCLES=4, sw=8'hFF held through reset, then release -> all outputs 0 during reset. sw_state=8'hFF exactly 6 edges after release; sw_rise=8'hFF for one cycle; evt_valid=1 with evt_data=8'hFF.
- DEBOUNCE_CYCLES=4, sw[0] pulsed high 3 cycles then low, repeated 5 times -> sw_state stays 8'h00; no sw_rise; evt_valid stays 0.
- DEBOUNCE_CYCLES=4, sw[3] 0->1 held -> sw_state=8'h08 at edge 6; sw_rise=8'h08 one cycle. Release -> sw_fall=8'h08 six edges later.
- evt_ready=0; sw[1] then sw[2] pressed 20 cycles apart -> evt_data 8'h02 then 8'h06; evt_overrun=1. Then evt_ready=1 one cycle -> evt_valid=0, evt_overrun=0.
- Event pending, evt_ready=1 in the same cycle sw_state changes to 8'h10 -> evt_valid stays 1, evt_data=8'h10, evt_overrun=0.
- sys_init_ctrl_n asserted asynchronously mid-cycle, 2 cycles into a sw[7] debounce -> outputs clear immediately. After release, sw_state[7]=1 exactly 6 edges later.

Source files
------------

// File: rtl/switch8_reader.sv
// rtl/switch8_reader.sv - 8-bit switch synchroniser, debouncer, edge pulses and change-event record
module switch8_reader #(
    parameter int DEBOUNCE_CYCLES = 500000,
    parameter int CNT_W           = 20
) (
    input  logic       fpga_clk,
    input  logic       sys_init_ctrl_n,
    input  logic [7:0] sw,
    output logic [7:0] sw_state,
    output logic [7:0] sw_rise,
    output logic [7:0] sw_fall,
    output logic       evt_valid,
    output logic [7:0] evt_data,
    input  logic       evt_ready,
    output logic       evt_overrun
);

    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

    logic [7:0]       s1;
    logic [7:0]       s2;
    logic [CNT_W-1:0] cnt     [8];
    logic [CNT_W-1:0] cnt_nxt [8];
    logic [7:0]       state_nxt;
    logic             change;

    always_ff @(posedge fpga_clk or negedge sys_init_ctrl_n) begin
        if (!sys_init_ctrl_n) begin
            s1 <= '0;
            s2 <= '0;
        end else begin
            s1 <= sw;
            s2 <= s1;
        end
    end

    // A bit only moves once its synchronised level has disagreed for DEBOUNCE_CYCLES edges in a row.
    always_comb begin
        state_nxt = sw_state;
        for (int i = 0; i < 8; i++) begin
            cnt_nxt[i] = '0;
            if (s2[i] != sw_state[i]) begin
                if (cnt[i] == CNT_LAST)
                    state_nxt[i] = s2[i];
                else
                    cnt_nxt[i] = cnt[i] + CNT_W'(1);
            end
        end
    end

    always_ff @(posedge fpga_clk or negedge sys_init_ctrl_n) begin
        if (!sys_init_ctrl_n) begin
            for (int i = 0; i < 8; i++)
                cnt[i] <= '0;
            sw_state <= '0;
            sw_rise  <= '0;
            sw_fall  <= '0;
        end else begin
            for (int i = 0; i < 8; i++)
                cnt[i] <= cnt_nxt[i];
            sw_state <= state_nxt;
            sw_rise  <= state_nxt & ~sw_state;
            sw_fall  <= ~state_nxt & sw_state;
        end
    end

    assign change = |(sw_rise | sw_fall);

    // Newest snapshot always wins; overrun records that the consumer missed one.
    always_ff @(posedge fpga_clk or negedge sys_init_ctrl_n) begin
        if (!sys_init_ctrl_n) begin
            evt_valid   <= 1'b0;
            evt_data    <= '0;
            evt_overrun <= 1'b0;
        end else if (change) begin
            evt_valid <= 1'b1;
            evt_data  <= sw_state;
            if (evt_valid && evt_ready)
                evt_overrun <= 1'b0;
            else if (evt_valid)
                evt_overrun <= 1'b1;
        end else if (evt_valid && evt_ready) begin
            evt_valid   <= 1'b0;
            evt_overrun <= 1'b0;
        end
    end

endmodule

// File: tb/tb_switch8_reader.sv
// tb/tb_switch8_reader.sv - directed self-checking bench for switch8_reader
module tb_switch8_reader;

    logic       fpga_clk = 1'b0;
    logic       sys_init_ctrl_n = 1'b0;
    logic [7:0] sw = 8'h00;
    logic [7:0] sw_state, sw_rise, sw_fall, evt_data;
    logic       evt_valid, evt_ready = 1'b0, evt_overrun;

    int n_checks = 0;
    int n_fails  = 0;

    switch8_reader #(.DEBOUNCE_CYCLES(4), .CNT_W(3)) dut (
        .fpga_clk        (fpga_clk),
        .sys_init_ctrl_n (sys_init_ctrl_n),
        .sw              (sw),
        .sw_state        (sw_state),
        .sw_rise         (sw_rise),
        .sw_fall         (sw_fall),
        .evt_valid       (evt_valid),
        .evt_data        (evt_data),
        .evt_ready       (evt_ready),
        .evt_overrun     (evt_overrun)
    );

    always #5 fpga_clk = ~fpga_clk;

    task automatic tick(input int n);
        for (int k = 0; k < n; k++) begin
            @(posedge fpga_clk);
            #1;
        end
    endtask

    task automatic chk(input string tag, input logic [7:0] got, input logic [7:0] exp);
        n_checks++;
        assert (got === exp) else begin
            n_fails++;
            $error("FAIL %s observed=%h expected=%h", tag, got, exp);
        end
    endtask

    task automatic chk_all_zero(input string tag);
        chk({tag, "_state"}, sw_state, 8'h00);
        chk({tag, "_rise"}, sw_rise, 8'h00);
        chk({tag, "_fall"}, sw_fall, 8'h00);
        chk({tag, "_valid"}, {7'd0, evt_valid}, 8'h00);
        chk({tag, "_data"}, evt_data, 8'h00);
        chk({tag, "_ovr"}, {7'd0, evt_overrun}, 8'h00);
    endtask

    initial begin
        // 1: all pins on through reset
        sw = 8'hFF;
        tick(3);
        chk_all_zero("rst");
        sys_init_ctrl_n = 1'b1;
        tick(5);
        chk("t1_state_e5", sw_state, 8'h00);
        tick(1);
        chk("t1_state_e6", sw_state, 8'hFF);
        chk("t1_rise_e6", sw_rise, 8'hFF);
        chk("t1_valid_e6", {7'd0, evt_valid}, 8'h00);
        tick(1);
        chk("t1_rise_e7", sw_rise, 8'h00);
        chk("t1_valid_e7", {7'd0, evt_valid}, 8'h01);
        chk("t1_data_e7", evt_data, 8'hFF);

        // back to idle, draining events
        sw = 8'h00;
        evt_ready = 1'b1;
        tick(10);
        chk("idle_state", sw_state, 8'h00);
        chk("idle_valid", {7'd0, evt_valid}, 8'h00);
        evt_ready = 1'b0;

        // 2: bouncing sw[0] never accepted
        for (int r = 0; r < 5; r++) begin
            sw = 8'h01;
            for (int c = 0; c < 3; c++) begin
                tick(1);
                chk("t2_state", sw_state, 8'h00);
                chk("t2_rise", sw_rise, 8'h00);
            end
            sw = 8'h00;
            for (int c = 0; c < 3; c++) begin
                tick(1);
                chk("t2_state", sw_state, 8'h00);
                chk("t2_valid", {7'd0, evt_valid}, 8'h00);
            end
        end
        tick(4);
        chk("t2_state_end", sw_state, 8'h00);
        chk("t2_valid_end", {7'd0, evt_valid}, 8'h00);

        // 3: sw[3] press then release
        sw = 8'h08;
        tick(5);
        chk("t3_state_e5", sw_state, 8'h00);
        tick(1);
        chk("t3_state_e6", sw_state, 8'h08);
        chk("t3_rise_e6", sw_rise, 8'h08);
        tick(1);
        chk("t3_rise_e7", sw_rise, 8'h00);
        chk("t3_data_e7", evt_data, 8'h08);
        sw = 8'h00;
        tick(5);
        chk("t3_fall_e5", sw_fall, 8'h00);
        tick(1);
        chk("t3_fall_e6", sw_fall, 8'h08);
        chk("t3_state_rel", sw_state, 8'h00);
        evt_ready = 1'b1;
        tick(2);
        chk("t3_valid_drain", {7'd0, evt_valid}, 8'h00);
        chk("t3_ovr_drain", {7'd0, evt_overrun}, 8'h00);
        evt_ready = 1'b0;

        // 4: two presses without consumer -> overwrite and overrun
        sw = 8'h02;
        tick(7);
        chk("t4_valid_a", {7'd0, evt_valid}, 8'h01);
        chk("t4_data_a", evt_data, 8'h02);
        chk("t4_ovr_a", {7'd0, evt_overrun}, 8'h00);
        tick(13);
        chk("t4_data_hold", evt_data, 8'h02);
        sw = 8'h06;
        tick(7);
        chk("t4_data_b", evt_data, 8'h06);
        chk("t4_ovr_b", {7'd0, evt_overrun}, 8'h01);
        evt_ready = 1'b1;
        tick(1);
        evt_ready = 1'b0;
        chk("t4_valid_acc", {7'd0, evt_valid}, 8'h00);
        chk("t4_ovr_acc", {7'd0, evt_overrun}, 8'h00);

        // 5: accept and new change in the same cycle
        sw = 8'h00;
        tick(7);
        chk("t5_pending", {7'd0, evt_valid}, 8'h01);
        chk("t5_pending_data", evt_data, 8'h00);
        sw = 8'h10;
        tick(6);
        chk("t5_state", sw_state, 8'h10);
        evt_ready = 1'b1;
        tick(1);
        evt_ready = 1'b0;
        chk("t5_valid", {7'd0, evt_valid}, 8'h01);
        chk("t5_data", evt_data, 8'h10);
        chk("t5_ovr", {7'd0, evt_overrun}, 8'h00);
        tick(2);
        chk("t5_data_stable", evt_data, 8'h10);

        // 6: asynchronous reset mid-debounce of sw[7]
        sw = 8'h90;
        tick(4);
        #3;
        sys_init_ctrl_n = 1'b0;
        #1;
        chk_all_zero("t6_rst");
        tick(2);
        sys_init_ctrl_n = 1'b1;
        tick(5);
        chk("t6_state_e5", sw_state, 8'h00);
        tick(1);
        chk("t6_state_e6", sw_state, 8'h90);
        chk("t6_rise_e6", sw_rise, 8'h90);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
        $finish;
    end

endmodule
